// File: rtl/descriptor_arbiter_if.sv
// Descriptor arbiter bus interface.
// Bundles the four producer-side request/descriptor lanes, the downstream
// queue write port and the debug/statistic outputs of descriptor_arbiter.
//   master : producers and queue (drive requests/descriptors/full, see acks/writes)
//   slave  : the arbiter itself
// Optional statistic signals exist only when DESCRIPTOR_ARB_STATISTIC_EN is defined.
interface descriptor_arbiter_if;
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned DESC_W    = 57;
    localparam int unsigned PORT_W    = 2;
    localparam int unsigned CNT_W     = 16;

    logic [NUM_PORTS-1:0] iv_descriptor_wr;
    logic [DESC_W-1:0]    iv_descriptor_p0;
    logic [DESC_W-1:0]    iv_descriptor_p1;
    logic [DESC_W-1:0]    iv_descriptor_p2;
    logic [DESC_W-1:0]    iv_descriptor_p3;
    logic [NUM_PORTS-1:0] iv_inverse_map_lookup_flag;
    logic [NUM_PORTS-1:0] ov_descriptor_ack;
    logic                 i_queue_full;
    logic                 o_descriptor_wr;
    logic [DESC_W-1:0]    ov_descriptor;
    logic [PORT_W-1:0]    ov_src_port;
    logic                 o_inverse_map_lookup_flag;
    logic                 ov_arb_state;
`ifdef DESCRIPTOR_ARB_STATISTIC_EN
    logic [CNT_W-1:0]     ov_grant_cnt_p0;
    logic [CNT_W-1:0]     ov_grant_cnt_p1;
    logic [CNT_W-1:0]     ov_grant_cnt_p2;
    logic [CNT_W-1:0]     ov_grant_cnt_p3;
    logic                 o_queue_full_stall;

    modport master (
        output iv_descriptor_wr, iv_descriptor_p0, iv_descriptor_p1,
               iv_descriptor_p2, iv_descriptor_p3, iv_inverse_map_lookup_flag,
               i_queue_full,
        input  ov_descriptor_ack, o_descriptor_wr, ov_descriptor, ov_src_port,
               o_inverse_map_lookup_flag, ov_arb_state,
               ov_grant_cnt_p0, ov_grant_cnt_p1, ov_grant_cnt_p2, ov_grant_cnt_p3,
               o_queue_full_stall
    );
    modport slave (
        input  iv_descriptor_wr, iv_descriptor_p0, iv_descriptor_p1,
               iv_descriptor_p2, iv_descriptor_p3, iv_inverse_map_lookup_flag,
               i_queue_full,
        output ov_descriptor_ack, o_descriptor_wr, ov_descriptor, ov_src_port,
               o_inverse_map_lookup_flag, ov_arb_state,
               ov_grant_cnt_p0, ov_grant_cnt_p1, ov_grant_cnt_p2, ov_grant_cnt_p3,
               o_queue_full_stall
    );
`else
    modport master (
        output iv_descriptor_wr, iv_descriptor_p0, iv_descriptor_p1,
               iv_descriptor_p2, iv_descriptor_p3, iv_inverse_map_lookup_flag,
               i_queue_full,
        input  ov_descriptor_ack, o_descriptor_wr, ov_descriptor, ov_src_port,
               o_inverse_map_lookup_flag, ov_arb_state
    );
    modport slave (
        input  iv_descriptor_wr, iv_descriptor_p0, iv_descriptor_p1,
               iv_descriptor_p2, iv_descriptor_p3, iv_inverse_map_lookup_flag,
               i_queue_full,
        output ov_descriptor_ack, o_descriptor_wr, ov_descriptor, ov_src_port,
               o_inverse_map_lookup_flag, ov_arb_state
    );
`endif
endinterface

// File: rtl/descriptor_arbiter.sv
// descriptor_arbiter: shares one descriptor queue write port among four
// frame-parser channels. Grants one requesting channel per two cycles
// (ARB_IDLE grants, ARB_HOLD lets the winner drop its request), forwarding
// the descriptor, its source-port tag and inverse-map flag with a one-cycle
// write strobe and a one-cycle ack to the winner.
// Ports:
//   clk_sys  system clock, rising edge
//   reset    synchronous active-high reset
//   arb_if   descriptor_arbiter_if.slave (requests, descriptors, flags,
//            queue full, acks, queue write, debug state)
// Parameter ARB_MODE: 0 = round-robin, 1 = fixed priority (port 0 highest).
// Optional macro DESCRIPTOR_ARB_STATISTIC_EN adds per-port 16-bit grant
// counters and a queue-full stall pulse.
module descriptor_arbiter #(
    parameter int unsigned ARB_MODE = 0
) (
    input  logic              clk_sys,
    input  logic              reset,
    descriptor_arbiter_if.slave arb_if
);
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned DESC_W    = 57;
    localparam int unsigned PORT_W    = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    arb_state_t           state_q, state_d;
    logic [PORT_W-1:0]    last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic                 wr_q, wr_d;
    logic [DESC_W-1:0]    desc_q, desc_d;
    logic [PORT_W-1:0]    src_q, src_d;
    logic                 flag_q, flag_d;

    logic [PORT_W-1:0]    winner_c;
    logic [DESC_W-1:0]    winner_desc_c;
    logic                 req_any_c;

    assign req_any_c = |arb_if.iv_descriptor_wr;

    // Winner select; loops run from last to first search position so the
    // first requesting position in search order is the final assignment.
    always_comb begin
        winner_c = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (arb_if.iv_descriptor_wr[i]) winner_c = PORT_W'(i);
            end
        end else begin
            for (int i = NUM_PORTS; i >= 1; i--) begin
                if (arb_if.iv_descriptor_wr[last_grant_q + PORT_W'(i)])
                    winner_c = last_grant_q + PORT_W'(i);
            end
        end
    end

    always_comb begin
        case (winner_c)
            2'd0:    winner_desc_c = arb_if.iv_descriptor_p0;
            2'd1:    winner_desc_c = arb_if.iv_descriptor_p1;
            2'd2:    winner_desc_c = arb_if.iv_descriptor_p2;
            default: winner_desc_c = arb_if.iv_descriptor_p3;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ack_d        = '0;
        wr_d         = 1'b0;
        desc_d       = desc_q;
        src_d        = src_q;
        flag_d       = flag_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_any_c && !arb_if.i_queue_full) begin
                    desc_d           = winner_desc_c;
                    src_d            = winner_c;
                    flag_d           = arb_if.iv_inverse_map_lookup_flag[winner_c];
                    wr_d             = 1'b1;
                    ack_d[winner_c]  = 1'b1;
                    last_grant_d     = winner_c;
                    state_d          = ARB_HOLD;
                end
            end
            // Requester still shows its request this cycle; never regrant it.
            ARB_HOLD: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 2'd3;
            ack_q        <= '0;
            wr_q         <= 1'b0;
            desc_q       <= '0;
            src_q        <= '0;
            flag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            wr_q         <= wr_d;
            desc_q       <= desc_d;
            src_q        <= src_d;
            flag_q       <= flag_d;
        end
    end

    assign arb_if.ov_descriptor_ack         = ack_q;
    assign arb_if.o_descriptor_wr           = wr_q;
    assign arb_if.ov_descriptor             = desc_q;
    assign arb_if.ov_src_port               = src_q;
    assign arb_if.o_inverse_map_lookup_flag = flag_q;
    assign arb_if.ov_arb_state              = state_q;

`ifdef DESCRIPTOR_ARB_STATISTIC_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] grant_cnt_q [NUM_PORTS];
    logic             stall_q, stall_d;

    // Pending request held off only by a full queue.
    assign stall_d = (state_q == ARB_IDLE) && req_any_c && arb_if.i_queue_full;

    // Counters count acks as they are issued; natural 16-bit wrap.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int n = 0; n < NUM_PORTS; n++) grant_cnt_q[n] <= '0;
            stall_q <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_PORTS; n++)
                grant_cnt_q[n] <= grant_cnt_q[n] + CNT_W'(ack_d[n]);
            stall_q <= stall_d;
        end
    end

    assign arb_if.ov_grant_cnt_p0    = grant_cnt_q[0];
    assign arb_if.ov_grant_cnt_p1    = grant_cnt_q[1];
    assign arb_if.ov_grant_cnt_p2    = grant_cnt_q[2];
    assign arb_if.ov_grant_cnt_p3    = grant_cnt_q[3];
    assign arb_if.o_queue_full_stall = stall_q;
`endif
endmodule

// File: tb/tb_descriptor_arbiter.sv
// Directed testbench for descriptor_arbiter: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_descriptor_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [56:0] D0 = 57'h0123_4567_89AB_C;
    localparam logic [56:0] D1 = 57'h1111_2222_3333_4;
    localparam logic [56:0] D2 = 57'h0ABC_DEF0_1234_5;
    localparam logic [56:0] D3 = 57'h1F00_0000_0000_7;

    always #5 clk = ~clk;

    descriptor_arbiter_if rr_if ();
    descriptor_arbiter_if fp_if ();

    descriptor_arbiter #(.ARB_MODE(0)) dut_rr (
        .clk_sys (clk),
        .reset   (reset),
        .arb_if  (rr_if)
    );

    descriptor_arbiter #(.ARB_MODE(1)) dut_fp (
        .clk_sys (clk),
        .reset   (reset),
        .arb_if  (fp_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if (rr_if.o_descriptor_wr !== 1'b0 || rr_if.ov_descriptor_ack !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_rr_strobes: wr=%b ack=%b expected wr=0 ack=0000",
                     rr_if.o_descriptor_wr, rr_if.ov_descriptor_ack);
        end
        n_tests++;
        if (rr_if.ov_descriptor !== 57'h0 || rr_if.ov_src_port !== 2'd0 ||
            rr_if.o_inverse_map_lookup_flag !== 1'b0 || rr_if.ov_arb_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rr_data: desc=%h src=%0d flag=%b state=%b expected all 0",
                     rr_if.ov_descriptor, rr_if.ov_src_port,
                     rr_if.o_inverse_map_lookup_flag, rr_if.ov_arb_state);
        end
        n_tests++;
        if (fp_if.o_descriptor_wr !== 1'b0 || fp_if.ov_descriptor_ack !== 4'b0 ||
            fp_if.ov_arb_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fp: wr=%b ack=%b state=%b expected 0 0000 0",
                     fp_if.o_descriptor_wr, fp_if.ov_descriptor_ack, fp_if.ov_arb_state);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        rr_if.iv_descriptor_wr           = 4'b0100;
        rr_if.iv_inverse_map_lookup_flag = 4'b0100;
        tick();
        n_tests++;
        if (rr_if.o_descriptor_wr !== 1'b1 || rr_if.ov_descriptor_ack !== 4'b0100 ||
            rr_if.ov_arb_state !== 1'b1) begin
            n_fail++;
            $display("FAIL single_strobe: wr=%b ack=%b state=%b expected 1 0100 1",
                     rr_if.o_descriptor_wr, rr_if.ov_descriptor_ack, rr_if.ov_arb_state);
        end
        n_tests++;
        if (rr_if.ov_descriptor !== D2 || rr_if.ov_src_port !== 2'd2 ||
            rr_if.o_inverse_map_lookup_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data: desc=%h src=%0d flag=%b expected %h 2 1",
                     rr_if.ov_descriptor, rr_if.ov_src_port,
                     rr_if.o_inverse_map_lookup_flag, D2);
        end
        rr_if.iv_descriptor_wr           = 4'b0000;
        rr_if.iv_inverse_map_lookup_flag = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (rr_if.o_descriptor_wr !== 1'b0 || rr_if.ov_descriptor_ack !== 4'b0) begin
                n_fail++;
                $display("FAIL single_no_rewrite[%0d]: wr=%b ack=%b expected 0 0000",
                         i, rr_if.o_descriptor_wr, rr_if.ov_descriptor_ack);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] dropped;
        logic [3:0] nxt;
        logic [1:0] exp_port;
        int         grants;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rr_if.iv_descriptor_wr = 4'b1111;
        dropped  = 4'b0;
        exp_port = 2'd0;
        grants   = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_tests++;
            if (rr_if.o_descriptor_wr !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL rr_cadence[%0d]: wr=%b expected %b",
                         i, rr_if.o_descriptor_wr, (i % 2) == 1);
            end
            if (rr_if.o_descriptor_wr === 1'b1) begin
                n_tests++;
                if (rr_if.ov_src_port !== exp_port ||
                    rr_if.ov_descriptor_ack !== (4'b0001 << exp_port)) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: src=%0d ack=%b expected src=%0d",
                             i, rr_if.ov_src_port, rr_if.ov_descriptor_ack, exp_port);
                end
                exp_port = exp_port + 2'd1;
                grants++;
            end
            // Requester model: drop on ack, re-raise one cycle later.
            nxt     = (rr_if.iv_descriptor_wr & ~rr_if.ov_descriptor_ack) | dropped;
            dropped = rr_if.ov_descriptor_ack;
            rr_if.iv_descriptor_wr = nxt;
        end
        n_tests++;
        if (grants != 8) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d expected 8", grants);
        end
        rr_if.iv_descriptor_wr = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_queue_full();
        int stalls;
        stalls = 0;
        rr_if.i_queue_full     = 1'b1;
        rr_if.iv_descriptor_wr = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (rr_if.o_descriptor_wr !== 1'b0 || rr_if.ov_descriptor_ack !== 4'b0) begin
                n_fail++;
                $display("FAIL full_blocked[%0d]: wr=%b ack=%b expected 0 0000",
                         i, rr_if.o_descriptor_wr, rr_if.ov_descriptor_ack);
            end
`ifdef DESCRIPTOR_ARB_STATISTIC_EN
            if (rr_if.o_queue_full_stall === 1'b1) stalls++;
`endif
        end
        rr_if.i_queue_full = 1'b0;
        tick();
        n_tests++;
        if (rr_if.o_descriptor_wr !== 1'b1 || rr_if.ov_descriptor_ack !== 4'b0010 ||
            rr_if.ov_src_port !== 2'd1 || rr_if.ov_descriptor !== D1) begin
            n_fail++;
            $display("FAIL full_release: wr=%b ack=%b src=%0d desc=%h expected 1 0010 1 %h",
                     rr_if.o_descriptor_wr, rr_if.ov_descriptor_ack,
                     rr_if.ov_src_port, rr_if.ov_descriptor, D1);
        end
`ifdef DESCRIPTOR_ARB_STATISTIC_EN
        if (rr_if.o_queue_full_stall === 1'b1) stalls++;
        n_tests++;
        if (stalls != 10) begin
            n_fail++;
            $display("FAIL full_stall_pulses: got %0d expected 10", stalls);
        end
`endif
        rr_if.iv_descriptor_wr = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_fixed_priority();
        int p0_grants;
        p0_grants = 0;
        fp_if.iv_descriptor_wr = 4'b1001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++;
            if (fp_if.ov_descriptor_ack[3] !== 1'b0 ||
                (fp_if.o_descriptor_wr === 1'b1 && fp_if.ov_src_port !== 2'd0)) begin
                n_fail++;
                $display("FAIL fp_port0_only[%0d]: wr=%b src=%0d ack=%b expected src=0",
                         i, fp_if.o_descriptor_wr, fp_if.ov_src_port, fp_if.ov_descriptor_ack);
            end
            if (fp_if.o_descriptor_wr === 1'b1) p0_grants++;
        end
        n_tests++;
        if (p0_grants != 4) begin
            n_fail++;
            $display("FAIL fp_p0_count: got %0d expected 4", p0_grants);
        end
        fp_if.iv_descriptor_wr = 4'b1000;
        tick();
        n_tests++;
        if (fp_if.o_descriptor_wr !== 1'b1 || fp_if.ov_src_port !== 2'd3 ||
            fp_if.ov_descriptor_ack !== 4'b1000 || fp_if.ov_descriptor !== D3) begin
            n_fail++;
            $display("FAIL fp_port3: wr=%b src=%0d ack=%b desc=%h expected 1 3 1000 %h",
                     fp_if.o_descriptor_wr, fp_if.ov_src_port,
                     fp_if.ov_descriptor_ack, fp_if.ov_descriptor, D3);
        end
        fp_if.iv_descriptor_wr = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_in_hold();
        rr_if.iv_descriptor_wr           = 4'b0010;
        rr_if.iv_inverse_map_lookup_flag = 4'b0010;
        tick();
        n_tests++;
        if (rr_if.o_descriptor_wr !== 1'b1 || rr_if.ov_src_port !== 2'd1 ||
            rr_if.o_inverse_map_lookup_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_pre_grant: wr=%b src=%0d flag=%b expected 1 1 1",
                     rr_if.o_descriptor_wr, rr_if.ov_src_port, rr_if.o_inverse_map_lookup_flag);
        end
        reset                            = 1'b1;
        rr_if.iv_descriptor_wr           = 4'b1111;
        rr_if.iv_inverse_map_lookup_flag = 4'b0000;
        tick();
        n_tests++;
        if (rr_if.o_descriptor_wr !== 1'b0 || rr_if.ov_descriptor_ack !== 4'b0 ||
            rr_if.ov_descriptor !== 57'h0 || rr_if.ov_src_port !== 2'd0 ||
            rr_if.o_inverse_map_lookup_flag !== 1'b0 || rr_if.ov_arb_state !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_reset: wr=%b ack=%b desc=%h src=%0d flag=%b state=%b expected all 0",
                     rr_if.o_descriptor_wr, rr_if.ov_descriptor_ack, rr_if.ov_descriptor,
                     rr_if.ov_src_port, rr_if.o_inverse_map_lookup_flag, rr_if.ov_arb_state);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (rr_if.o_descriptor_wr !== 1'b1 || rr_if.ov_src_port !== 2'd0 ||
            rr_if.ov_descriptor_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold_after_reset: wr=%b src=%0d ack=%b expected 1 0 0001",
                     rr_if.o_descriptor_wr, rr_if.ov_src_port, rr_if.ov_descriptor_ack);
        end
`ifdef DESCRIPTOR_ARB_STATISTIC_EN
        n_tests++;
        if (rr_if.ov_grant_cnt_p0 !== 16'd1 || rr_if.ov_grant_cnt_p1 !== 16'd0 ||
            rr_if.ov_grant_cnt_p2 !== 16'd0 || rr_if.ov_grant_cnt_p3 !== 16'd0) begin
            n_fail++;
            $display("FAIL stat_counters: p0=%0d p1=%0d p2=%0d p3=%0d expected 1 0 0 0",
                     rr_if.ov_grant_cnt_p0, rr_if.ov_grant_cnt_p1,
                     rr_if.ov_grant_cnt_p2, rr_if.ov_grant_cnt_p3);
        end
`endif
        rr_if.iv_descriptor_wr = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        rr_if.iv_descriptor_wr           = 4'b0;
        rr_if.iv_inverse_map_lookup_flag = 4'b0;
        rr_if.i_queue_full               = 1'b0;
        rr_if.iv_descriptor_p0           = D0;
        rr_if.iv_descriptor_p1           = D1;
        rr_if.iv_descriptor_p2           = D2;
        rr_if.iv_descriptor_p3           = D3;
        fp_if.iv_descriptor_wr           = 4'b0;
        fp_if.iv_inverse_map_lookup_flag = 4'b0;
        fp_if.i_queue_full               = 1'b0;
        fp_if.iv_descriptor_p0           = D0;
        fp_if.iv_descriptor_p1           = D1;
        fp_if.iv_descriptor_p2           = D2;
        fp_if.iv_descriptor_p3           = D3;

        test_reset();
        test_single();
        test_round_robin();
        test_queue_full();
        test_fixed_priority();
        test_reset_in_hold();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
